// File: rtl/psum_accum_ctrl.sv
// Output-path engine between the OFIFO and the output SRAM.
// Drains OFIFO rows, merges partial sums lane by lane and writes results back.
module psum_accum_ctrl #(
    parameter int col      = 8,
    parameter int psum_bw  = 32,
    parameter int addr_bw  = 11,
    parameter int SRAM_LAT = 1,
    parameter int SAT      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw-1:0]       num_rows,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   ofifo_data,
    output logic                     sram_rd_en,
    output logic [addr_bw-1:0]       sram_rd_addr,
    input  logic [col*psum_bw-1:0]   sram_rd_data,
    output logic                     sram_wr_en,
    output logic [addr_bw-1:0]       sram_wr_addr,
    output logic [col*psum_bw-1:0]   sram_wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int W = col * psum_bw;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic [1:0]           mode_q;
    logic [addr_bw-1:0]   base_q;
    logic [addr_bw-1:0]   num_q;
    logic [addr_bw-1:0]   issued;
    logic [addr_bw-1:0]   cur_addr;
    logic                 fire;
    logic                 acc;
    logic [SRAM_LAT-1:0]  vld;
    logic [addr_bw-1:0]   vaddr [SRAM_LAT];
    logic [W-1:0]         o_al;
    logic [W-1:0]         res;

    assign fire     = (state == RUN) && ofifo_valid && (issued != num_q);
    assign acc      = mode_q[0] ^ mode_q[1];
    assign cur_addr = base_q + issued;

    assign ofifo_rd     = fire;
    assign sram_rd_en   = fire && acc;
    assign sram_rd_addr = sram_rd_en ? cur_addr : '0;
    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mode_q <= '0;
            base_q <= '0;
            num_q  <= '0;
            issued <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                mode_q <= mode;
                base_q <= base_addr;
                num_q  <= num_rows;
                issued <= '0;
            end else if (fire) begin
                issued <= issued + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = (num_rows == '0) ? DONE : RUN;
            RUN:   if (issued == num_q) state_nx = DRAIN;
            DRAIN: if (vld == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    // Row tag pipeline: one slot per cycle of SRAM read latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int k = 0; k < SRAM_LAT; k++) vaddr[k] <= '0;
        end else begin
            vld[0]   <= fire;
            vaddr[0] <= cur_addr;
            for (int k = 1; k < SRAM_LAT; k++) begin
                vld[k]   <= vld[k-1];
                vaddr[k] <= vaddr[k-1];
            end
        end
    end

    // OFIFO data arrives one cycle after the pop; stretch it to meet the SRAM data
    generate
        if (SRAM_LAT == 1) begin : g_nodly
            assign o_al = ofifo_data;
        end else begin : g_dly
            logic [W-1:0] sh [SRAM_LAT-1];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < SRAM_LAT-1; k++) sh[k] <= '0;
                end else begin
                    sh[0] <= ofifo_data;
                    for (int k = 1; k < SRAM_LAT-1; k++) sh[k] <= sh[k-1];
                end
            end
            assign o_al = sh[SRAM_LAT-2];
        end
    endgenerate

    always_comb begin : lane_math
        logic signed [psum_bw-1:0] o, s, sumr, r;
        logic        [psum_bw:0]   sum;
        res  = '0;
        o    = '0;
        s    = '0;
        sumr = '0;
        r    = '0;
        sum  = '0;
        for (int i = 0; i < col; i++) begin
            o   = o_al[i*psum_bw +: psum_bw];
            s   = sram_rd_data[i*psum_bw +: psum_bw];
            sum = {o[psum_bw-1], o} + {s[psum_bw-1], s};
            if (SAT != 0 && (sum[psum_bw] != sum[psum_bw-1]))
                sumr = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                    : {1'b0, {(psum_bw-1){1'b1}}};
            else
                sumr = sum[psum_bw-1:0];
            unique case (mode_q)
                2'b00: r = o;
                2'b01: r = sumr;
                2'b10: r = sumr[psum_bw-1] ? '0 : sumr;
                2'b11: r = o[psum_bw-1] ? '0 : o;
            endcase
            res[i*psum_bw +: psum_bw] = r;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_wr_en   <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
        end else begin
            sram_wr_en <= vld[SRAM_LAT-1];
            if (vld[SRAM_LAT-1]) begin
                sram_wr_addr <= vaddr[SRAM_LAT-1];
                sram_wr_data <= res;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl: four instances (SRAM_LAT 1/2/3 wrap, 1 saturating)
// share one stimulus and are checked against a timeline model every cycle.
module tb_psum_accum_ctrl;

    localparam int COL = 8;
    localparam int PBW = 32;
    localparam int AW  = 11;
    localparam int W   = COL * PBW;
    localparam int NI  = 4;
    localparam longint PMAX = 64'sd2147483647;
    localparam longint PMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic [W-1:0]  ofifo_data = '0;

    logic          rd_a   [NI];
    logic          rden_a [NI];
    logic          wren_a [NI];
    logic          busy_a [NI];
    logic          done_a [NI];
    logic [AW-1:0] rdad_a [NI];
    logic [AW-1:0] wrad_a [NI];
    logic [W-1:0]  rdd_a  [NI];
    logic [W-1:0]  wrd_a  [NI];

    logic [W-1:0]  smem [2048];
    logic [W-1:0]  orow [16];
    logic [W-1:0]  srow [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT  = (g == 3) ? 1 : g + 1;
        localparam int SATP = (g == 3) ? 1 : 0;
        logic [W-1:0] rp [3];
        always @(posedge clk) begin
            rp[0] <= smem[rdad_a[g]];
            rp[1] <= rp[0];
            rp[2] <= rp[1];
        end
        assign rdd_a[g] = rp[LAT-1];
        psum_accum_ctrl #(
            .col(COL), .psum_bw(PBW), .addr_bw(AW),
            .SRAM_LAT(LAT), .SAT(SATP)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start), .mode(mode),
            .base_addr(base_addr), .num_rows(num_rows),
            .ofifo_valid(ofifo_valid), .ofifo_rd(rd_a[g]),
            .ofifo_data(ofifo_data),
            .sram_rd_en(rden_a[g]), .sram_rd_addr(rdad_a[g]),
            .sram_rd_data(rdd_a[g]),
            .sram_wr_en(wren_a[g]), .sram_wr_addr(wrad_a[g]),
            .sram_wr_data(wrd_a[g]),
            .busy(busy_a[g]), .done(done_a[g])
        );
    end

    typedef struct {
        longint        due;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    wr_t           wq [NI][$];
    int            tests = 0;
    int            errs = 0;
    longint        cyc = 0;
    bit            m_run = 0;
    int            m_issued = 0;
    int            m_num = 0;
    logic [1:0]    m_mode = '0;
    logic [AW-1:0] m_base = '0;
    bit            open [NI];
    longint        done_c [NI];
    longint        start_c = 0;
    longint        first_wr_c [NI];
    longint        dut_done_c [NI];
    int            wcnt [NI];
    int            dcnt [NI];
    int            rdcnt [NI];
    logic [31:0]   last_l0 [NI];
    logic [AW-1:0] waddr0 [16];
    bit            pop_flag = 0;
    int            pop_idx = 0;

    function automatic int lat_of(int g);
        return (g == 3) ? 1 : g + 1;
    endfunction

    task automatic chkw(string nm, int g, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] @%0d: got %h want %h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic chka(string nm, int g, longint act, longint exp);
        tests++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0d want %0d", nm, g, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_res(logic [31:0] o, logic [31:0] s,
                                             logic [1:0] md, bit sat);
        longint a = longint'(signed'(o));
        longint b = longint'(signed'(s));
        longint r;
        if (md == 2'd0) r = a;
        else if (md == 2'd3) r = (a < 0) ? 0 : a;
        else begin
            r = a + b;
            if (sat) begin
                if (r > PMAX) r = PMAX;
                if (r < PMIN) r = PMIN;
            end else begin
                r = longint'(signed'(r[31:0]));
            end
            if (md == 2'd2 && r < 0) r = 0;
        end
        return r[31:0];
    endfunction

    function automatic logic [W-1:0] row_res(logic [W-1:0] o, logic [W-1:0] s,
                                             logic [1:0] md, bit sat);
        logic [W-1:0] v = '0;
        for (int i = 0; i < COL; i++)
            v[i*32 +: 32] = lane_res(o[i*32 +: 32], s[i*32 +: 32], md, sat);
        return v;
    endfunction

    function automatic logic [W-1:0] mk(int v0, int step, int r);
        logic [W-1:0] v = '0;
        for (int i = 0; i < COL; i++)
            v[i*32 +: 32] = v0 + (i + r * COL) * step;
        return v;
    endfunction

    task automatic model_step();
        bit            exp_pop, exp_rd, ew;
        logic [AW-1:0] ea;
        cyc++;
        if (!reset) begin
            for (int g = 0; g < NI; g++) begin
                chka("rst_rd", g, longint'(rd_a[g]), 0);
                chka("rst_rden", g, longint'(rden_a[g]), 0);
                chka("rst_rdad", g, longint'(rdad_a[g]), 0);
                chka("rst_wren", g, longint'(wren_a[g]), 0);
                chka("rst_wrad", g, longint'(wrad_a[g]), 0);
                chkw("rst_wrd", g, wrd_a[g], '0);
                chka("rst_busy", g, longint'(busy_a[g]), 0);
                chka("rst_done", g, longint'(done_a[g]), 0);
                open[g] = 0;
                done_c[g] = -1;
                wq[g].delete();
                wcnt[g] = 0;
                dcnt[g] = 0;
            end
            m_run = 0;
            m_issued = 0;
            pop_flag = 0;
            return;
        end
        exp_pop = m_run && ofifo_valid && (m_issued < m_num);
        exp_rd  = exp_pop && (m_mode == 2'd1 || m_mode == 2'd2);
        ea      = m_base + AW'(m_issued);
        for (int g = 0; g < NI; g++) begin
            chka("ofifo_rd", g, longint'(rd_a[g]), longint'(exp_pop));
            chka("sram_rd_en", g, longint'(rden_a[g]), longint'(exp_rd));
            if (exp_rd) chka("sram_rd_addr", g, longint'(rdad_a[g]), longint'(ea));
            ew = (wq[g].size() > 0) && (wq[g][0].due == cyc);
            chka("sram_wr_en", g, longint'(wren_a[g]), longint'(ew));
            if (ew) begin
                chka("sram_wr_addr", g, longint'(wrad_a[g]), longint'(wq[g][0].addr));
                chkw("sram_wr_data", g, wrd_a[g], wq[g][0].data);
                void'(wq[g].pop_front());
            end
            if (wren_a[g]) begin
                wcnt[g]++;
                last_l0[g] = wrd_a[g][31:0];
                if (wcnt[g] == 1) first_wr_c[g] = cyc;
                if (g == 0 && wcnt[g] <= 16) waddr0[wcnt[g]-1] = wrad_a[g];
            end
            if (rden_a[g]) rdcnt[g]++;
            if (done_a[g]) begin
                dcnt[g]++;
                dut_done_c[g] = cyc;
            end
            chka("busy", g, longint'(busy_a[g]), longint'(open[g] && cyc != done_c[g]));
            chka("done", g, longint'(done_a[g]), longint'(open[g] && cyc == done_c[g]));
        end
        pop_flag = exp_pop;
        if (exp_pop) begin
            pop_idx = m_issued;
            for (int g = 0; g < NI; g++) begin
                wr_t w;
                w.due  = cyc + lat_of(g) + 1;
                w.addr = ea;
                w.data = row_res(orow[m_issued], srow[m_issued], m_mode, g == 3);
                wq[g].push_back(w);
                if (m_issued + 1 == m_num) done_c[g] = cyc + lat_of(g) + 2;
            end
            m_issued++;
            if (m_issued == m_num) m_run = 0;
        end
        if (start && !open[0]) begin
            m_mode = mode;
            m_base = base_addr;
            m_num = int'(num_rows);
            m_issued = 0;
            m_run = (num_rows != '0);
            start_c = cyc;
            for (int g = 0; g < NI; g++) begin
                open[g] = 1;
                done_c[g] = (num_rows == '0) ? cyc + 1 : -1;
                wcnt[g] = 0;
                dcnt[g] = 0;
                rdcnt[g] = 0;
                dut_done_c[g] = -1;
                first_wr_c[g] = -1;
            end
        end else begin
            for (int g = 0; g < NI; g++)
                if (open[g] && cyc == done_c[g]) open[g] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (pop_flag) ofifo_data = orow[pop_idx];
    endtask

    task automatic run(input logic [1:0] md, input int base, input int num,
                       input int o0, input int os, input int s0, input int ss,
                       input bit bub, input bit ign, input int rst_at);
        bit fin = 0;
        for (int r = 0; r < num && r < 16; r++) begin
            logic [AW-1:0] a;
            orow[r] = mk(o0, os, r);
            srow[r] = mk(s0, ss, r);
            a = AW'(base + r);
            smem[a] = srow[r];
        end
        mode = md;
        base_addr = AW'(base);
        num_rows = AW'(num);
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = ~md;
        base_addr = AW'(base + 5);
        num_rows = AW'(num + 3);
        for (int k = 0; k < 300 && !fin; k++) begin
            ofifo_valid = bub ? (k % 3 == 0) : 1'b1;
            start = ign && (k == 2);
            tick();
            if (rst_at > 0 && m_run && m_issued == rst_at) begin
                reset = 1'b0;
                start = 1'b0;
                tick();
                tick();
                reset = 1'b1;
                for (int j = 0; j < 8; j++) tick();
            end
            fin = !(open[0] || open[1] || open[2] || open[3]);
        end
        if (!fin) chka("tile_timeout", 0, 0, 1);
        start = 1'b0;
        ofifo_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            open[g] = 0;
            done_c[g] = -1;
            wcnt[g] = 0;
            dcnt[g] = 0;
            rdcnt[g] = 0;
            last_l0[g] = '0;
            first_wr_c[g] = -1;
            dut_done_c[g] = -1;
        end
        tick();
        tick();
        reset = 1'b1;
        tick();

        chka("pin_acc", 0, longint'(lane_res(32'd5, 32'hFFFF_FFF9, 2'd1, 0)), 64'hFFFF_FFFE);
        chka("pin_relu", 0, longint'(lane_res(32'd5, 32'hFFFF_FFF9, 2'd2, 0)), 0);
        chka("pin_relu_only", 0, longint'(lane_res(32'hFFFF_FFFD, 32'd9, 2'd3, 0)), 0);
        chka("pin_sat", 0, longint'(lane_res(32'h7FFF_FFF0, 32'h20, 2'd1, 1)), 64'h7FFF_FFFF);
        chka("pin_wrap", 0, longint'(lane_res(32'h7FFF_FFF0, 32'h20, 2'd1, 0)), 64'h8000_0010);

        run(2'd0, 'h010, 4, 1000, 11, 77, 5, 0, 0, 0);
        for (int g = 0; g < NI; g++) begin
            chka("t1_wcnt", g, wcnt[g], 4);
            chka("t1_first_wr", g, first_wr_c[g] - start_c, lat_of(g) + 2);
            chka("t1_done_at", g, dut_done_c[g] - start_c, lat_of(g) + 6);
        end
        chka("t1_addr0", 0, longint'(waddr0[0]), 'h010);
        chka("t1_addr3", 0, longint'(waddr0[3]), 'h013);

        run(2'd1, 'h040, 2, 5, 0, -7, 0, 0, 0, 0);
        for (int g = 0; g < NI; g++) chka("t2_acc", g, longint'(last_l0[g]), 64'hFFFF_FFFE);
        run(2'd2, 'h040, 2, 5, 0, -7, 0, 0, 0, 0);
        for (int g = 0; g < NI; g++) chka("t2_relu", g, longint'(last_l0[g]), 0);
        run(2'd3, 'h048, 2, -3, 0, 9, 0, 0, 0, 0);
        for (int g = 0; g < NI; g++) begin
            chka("t2_relu_only", g, longint'(last_l0[g]), 0);
            chka("t2_no_read", g, rdcnt[g], 0);
        end

        run(2'd1, 'h080, 1, 'h7FFF_FFF0, 1, 'h20, 0, 0, 0, 0);
        chka("t3_sat", 3, longint'(last_l0[3]), 64'h7FFF_FFFF);
        chka("t3_wrap", 0, longint'(last_l0[0]), 64'h8000_0010);

        run(2'd1, 'h100, 6, 100, 3, -50, 7, 1, 1, 0);
        for (int g = 0; g < NI; g++) begin
            chka("t4_wcnt", g, wcnt[g], 6);
            chka("t4_rdcnt", g, rdcnt[g], 6);
            chka("t4_dcnt", g, dcnt[g], 1);
        end
        for (int i = 0; i < 6; i++) chka("t4_order", i, longint'(waddr0[i]), 'h100 + i);

        run(2'd1, 2046, 4, -9, 2, 40, -3, 0, 0, 0);
        chka("t5_wrap0", 0, longint'(waddr0[0]), 2046);
        chka("t5_wrap1", 0, longint'(waddr0[1]), 2047);
        chka("t5_wrap2", 0, longint'(waddr0[2]), 0);
        chka("t5_wrap3", 0, longint'(waddr0[3]), 1);
        run(2'd1, 'h020, 0, 1, 1, 1, 1, 0, 0, 0);
        for (int g = 0; g < NI; g++) begin
            chka("t5_zero_done", g, dut_done_c[g] - start_c, 1);
            chka("t5_zero_wr", g, wcnt[g], 0);
            chka("t5_zero_rd", g, rdcnt[g], 0);
        end

        run(2'd2, 'h200, 8, -20, 5, 3, -1, 0, 0, 3);
        for (int g = 0; g < NI; g++) begin
            chka("t6_no_wr", g, wcnt[g], 0);
            chka("t6_no_done", g, dcnt[g], 0);
        end
        run(2'd1, 'h300, 5, 7, -2, 1000, 13, 0, 0, 0);
        for (int g = 0; g < NI; g++) begin
            chka("t6_fresh_wr", g, wcnt[g], 5);
            chka("t6_fresh_done", g, dcnt[g], 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
